// File: rtl/debounce_pkg.sv
// Shared types for the push-button debouncer.
// State encoding and default debounce length.
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/debounce_if.sv
// Button-side bundle: raw level in,
// debounced level and press pulse out.
interface debounce_if;

  logic btn_in;
  logic pulse;
  logic level;

  modport master (
    output btn_in,
    input  pulse,
    input  level
  );

  modport slave (
    input  btn_in,
    output pulse,
    output level
  );

endinterface

// File: rtl/debounce_pulse_sync2.sv
// Two-flop synchronizer, reset to 0.
// Reusable for any slow switch input.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// Debounced level plus one-cycle press pulse
// for a bouncing push button.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  debounce_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM =
    CW'(DEBOUNCE_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          pulse_nx;
  logic          level_nx;
  logic          s2;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (s2)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      LOW: begin
        if (s2) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else if (cnt == TERM) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nx = WAIT_LOW;
          cnt_nx   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == TERM) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
    endcase
    // only an accepted press pulses
    pulse_nx = (state == WAIT_HIGH) &&
               (state_nx == HIGH);
    level_nx = (state_nx == HIGH) ||
               (state_nx == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOW;
      cnt       <= '0;
      bus.pulse <= 1'b0;
      bus.level <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bus.pulse <= pulse_nx;
      bus.level <= level_nx;
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: table rows, corner
// sequences and random run-length reference model.
module tb_debounce_pulse;

  localparam int N = 4;

  typedef struct {
    logic [31:0] pat;
    int          len;
    int          n_pulse;
    int          first;
    int          fall;
    logic        lvl;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic model_on = 1'b0;

  always #5 clk = ~clk;

  debounce_if bus ();

  debounce_pulse #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // downstream modulo-4 counter fed by pulse
  logic [1:0] q;
  always @(posedge clk) begin
    if (reset) q <= 2'd0;
    else if (bus.pulse) q <= q + 2'd1;
  end

  // reference: a level flips once the synchronized
  // input has disagreed with it for N+1 samples
  logic m_s1, m_s2, m_level, m_pulse;
  int   m_run;
  always @(posedge clk) begin
    if (reset) begin
      m_s1    <= 1'b0;
      m_s2    <= 1'b0;
      m_run   <= 0;
      m_level <= 1'b0;
      m_pulse <= 1'b0;
    end else begin
      m_s1    <= bus.btn_in;
      m_s2    <= m_s1;
      m_pulse <= 1'b0;
      if (m_s2 == m_level) begin
        m_run <= 0;
      end else if (m_run == N) begin
        m_run   <= 0;
        m_level <= ~m_level;
        m_pulse <= ~m_level;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic check(
    input string nm,
    input logic signed [31:0] act,
    input logic signed [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("rand_pulse", 32'(bus.pulse),
            32'(m_pulse));
      check("rand_level", 32'(bus.level),
            32'(m_level));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.btn_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_row(input vec_t v,
                         input int r);
    int   np;
    int   first;
    int   fall;
    logic prev;
    np = 0;
    first = -1;
    fall = -1;
    do_reset();
    prev = bus.level;
    for (int e = 1; e <= v.len; e++) begin
      bus.btn_in = v.pat[e-1];
      tick();
      if (bus.pulse === 1'b1) begin
        np++;
        if (first < 0) first = e;
      end
      if (prev === 1'b1 && bus.level === 1'b0
          && fall < 0)
        fall = e;
      prev = bus.level;
    end
    check($sformatf("row%0d_npulse", r),
          np, v.n_pulse);
    check($sformatf("row%0d_first", r),
          first, v.first);
    check($sformatf("row%0d_fall", r),
          fall, v.fall);
    check($sformatf("row%0d_level", r),
          32'(bus.level), 32'(v.lvl));
  endtask

  vec_t       rows[8];
  logic [1:0] qexp[5];

  initial begin
    int k;
    int hold;
    rows[0] = '{32'h000F_FFFF, 20, 1, 7, -1, 1'b1};
    rows[1] = '{32'h00FF_FF33, 24, 1, 15, -1, 1'b1};
    rows[2] = '{32'h0000_CFFF, 32, 1, 7, 23, 1'b0};
    rows[3] = '{32'h0000_0007, 16, 0, -1, -1, 1'b0};
    rows[4] = '{32'h0000_000F, 16, 0, -1, -1, 1'b0};
    rows[5] = '{32'h0000_001F, 20, 1, 7, 12, 1'b0};
    rows[6] = '{32'h0000_7C1F, 24, 2, 7, 12, 1'b0};
    rows[7] = '{32'h0000_3E1F, 24, 1, 7, 21, 1'b0};
    qexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    bus.btn_in = 1'b0;
    do_reset();
    check("rst_pulse", 32'(bus.pulse), 0);
    check("rst_level", 32'(bus.level), 0);

    for (int r = 0; r < 8; r++)
      run_row(rows[r], r);

    // reset lands on the pulse cycle
    do_reset();
    bus.btn_in = 1'b1;
    k = 0;
    while (bus.pulse !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("s5_first_lat", k, 7);
    reset = 1'b1;
    tick();
    check("s5_rst_pulse", 32'(bus.pulse), 0);
    check("s5_rst_level", 32'(bus.level), 0);
    reset = 1'b0;
    k = 0;
    while (bus.pulse !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("s5_repress_lat", k, 7);
    tick();
    check("s5_width", 32'(bus.pulse), 0);

    // counter integration
    do_reset();
    for (int p = 0; p < 5; p++) begin
      bus.btn_in = 1'b1;
      repeat (8) tick();
      bus.btn_in = 1'b0;
      repeat (10) tick();
      check($sformatf("cnt_q%0d", p),
            32'(q), 32'(qexp[p]));
    end

    // random run lengths vs reference
    do_reset();
    model_on = 1'b1;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        bus.btn_in = ~bus.btn_in;
        hold = $urandom_range(1, 12);
      end
      hold--;
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    model_on = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
